// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - integer register file with two registered read ports and a pending-bit scoreboard
module regfile_scoreboard #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [ADDR_W-1:0] r2_addr,
  output logic [XLEN-1:0]   r1_data,
  output logic [XLEN-1:0]   r2_data,
  output logic              r1_busy,
  output logic              r2_busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_addr,
  output logic              pending_any
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pending;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] next_pending;

  logic [XLEN-1:0]  r1_data_nxt;
  logic [XLEN-1:0]  r2_data_nxt;
  logic             r1_busy_nxt;
  logic             r2_busy_nxt;

  // Scoreboard next state: writeback clears, reservation sets; a new producer wins over a retiring one.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wr_en) begin
      clr_vec[wr_addr] = 1'b1;
    end
    if (resv_en) begin
      set_vec[resv_addr] = 1'b1;
    end
    next_pending    = (pending & ~clr_vec) | set_vec;
    next_pending[0] = 1'b0;
  end

  // Read port 1 lookup; with bypass the port sees this edge's write and the post-edge pending bit.
  always_comb begin
    r1_data_nxt = regs[r1_addr];
    r1_busy_nxt = pending[r1_addr];
    if (r1_addr == '0) begin
      r1_data_nxt = '0;
      r1_busy_nxt = 1'b0;
    end else if (BYPASS != 0) begin
      if (wr_en && (wr_addr == r1_addr)) begin
        r1_data_nxt = wr_data;
      end
      r1_busy_nxt = next_pending[r1_addr];
    end
  end

  // Read port 2 lookup; identical rules to port 1.
  always_comb begin
    r2_data_nxt = regs[r2_addr];
    r2_busy_nxt = pending[r2_addr];
    if (r2_addr == '0) begin
      r2_data_nxt = '0;
      r2_busy_nxt = 1'b0;
    end else if (BYPASS != 0) begin
      if (wr_en && (wr_addr == r2_addr)) begin
        r2_data_nxt = wr_data;
      end
      r2_busy_nxt = next_pending[r2_addr];
    end
  end

  // Register array; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Pending bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= next_pending;
    end
  end

  // Registered read outputs; they hold while rd_en is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_data <= '0;
      r2_data <= '0;
      r1_busy <= 1'b0;
      r2_busy <= 1'b0;
    end else if (rd_en) begin
      r1_data <= r1_data_nxt;
      r2_data <= r2_data_nxt;
      r1_busy <= r1_busy_nxt;
      r2_busy <= r2_busy_nxt;
    end
  end

  assign pending_any = |pending;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - self-checking bench for regfile_scoreboard, bypass and non-bypass builds side by side
module tb_regfile_scoreboard;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  logic              clk;
  logic              rst_n;
  logic              rd_en;
  logic [ADDR_W-1:0] r1_addr, r2_addr, wr_addr, resv_addr;
  logic              wr_en, resv_en;
  logic [XLEN-1:0]   wr_data;

  // instance a: BYPASS=1, instance b: BYPASS=0
  logic [XLEN-1:0] a_r1_data, a_r2_data, b_r1_data, b_r2_data;
  logic            a_r1_busy, a_r2_busy, b_r1_busy, b_r2_busy;
  logic            a_pending_any, b_pending_any;

  int errors = 0;
  int checks = 0;

  // reference model state, index 0 = bypass build, 1 = non-bypass build
  logic [XLEN-1:0] m_regs [2][NREGS];
  bit              m_pend [2][NREGS];
  logic [XLEN-1:0] e_d1 [2];
  logic [XLEN-1:0] e_d2 [2];
  bit              e_b1 [2];
  bit              e_b2 [2];

  regfile_scoreboard #(.XLEN(XLEN), .ADDR_W(ADDR_W), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
    .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_data(a_r1_data), .r2_data(a_r2_data),
    .r1_busy(a_r1_busy), .r2_busy(a_r2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr),
    .pending_any(a_pending_any)
  );

  regfile_scoreboard #(.XLEN(XLEN), .ADDR_W(ADDR_W), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
    .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_data(b_r1_data), .r2_data(b_r2_data),
    .r1_busy(b_r1_busy), .r2_busy(b_r2_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .resv_en(resv_en), .resv_addr(resv_addr),
    .pending_any(b_pending_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[b][r] = '0;
        m_pend[b][r] = 1'b0;
      end
      e_d1[b] = '0; e_d2[b] = '0; e_b1[b] = 1'b0; e_b2[b] = 1'b0;
    end
  endtask

  function automatic bit any_pending(input int b);
    for (int r = 0; r < NREGS; r++) if (m_pend[b][r]) return 1'b1;
    return 1'b0;
  endfunction

  // what one read port should return for instance b at the coming edge
  task automatic model_read(input int b, input int addr, output logic [XLEN-1:0] d, output bit bz);
    bit will_be_pending;
    if (addr == 0) begin
      d = '0; bz = 1'b0;
    end else begin
      if (resv_en && resv_addr == addr)      will_be_pending = 1'b1;
      else if (wr_en && wr_addr == addr)     will_be_pending = 1'b0;
      else                                   will_be_pending = m_pend[b][addr];
      if (b == 0) begin
        d  = (wr_en && wr_addr == addr) ? wr_data : m_regs[b][addr];
        bz = will_be_pending;
      end else begin
        d  = m_regs[b][addr];
        bz = m_pend[b][addr];
      end
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ":a_r1_data"}, a_r1_data, e_d1[0]);
    chk({where, ":a_r2_data"}, a_r2_data, e_d2[0]);
    chk({where, ":a_r1_busy"}, a_r1_busy, e_b1[0]);
    chk({where, ":a_r2_busy"}, a_r2_busy, e_b2[0]);
    chk({where, ":a_pend_any"}, a_pending_any, any_pending(0));
    chk({where, ":b_r1_data"}, b_r1_data, e_d1[1]);
    chk({where, ":b_r2_data"}, b_r2_data, e_d2[1]);
    chk({where, ":b_r1_busy"}, b_r1_busy, e_b1[1]);
    chk({where, ":b_r2_busy"}, b_r2_busy, e_b2[1]);
    chk({where, ":b_pend_any"}, b_pending_any, any_pending(1));
  endtask

  // one clock: predict from current inputs, advance the model, then compare after the edge
  task automatic cycle(input string where);
    for (int b = 0; b < 2; b++) begin
      if (rd_en) begin
        model_read(b, int'(r1_addr), e_d1[b], e_b1[b]);
        model_read(b, int'(r2_addr), e_d2[b], e_b2[b]);
      end
      if (wr_en && wr_addr != 0) m_regs[b][wr_addr] = wr_data;
      if (wr_en)   m_pend[b][wr_addr]   = 1'b0;
      if (resv_en) m_pend[b][resv_addr] = 1'b1;
      m_pend[b][0] = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(where);
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; resv_en = 0;
    r1_addr = 0; r2_addr = 0; wr_addr = 0; resv_addr = 0; wr_data = '0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all("in_reset");
    rst_n = 1'b1;

    // reset then read
    rd_en = 1; r1_addr = 3; r2_addr = 0;
    cycle("rst_read");
    chk("rst_read_pend_any", a_pending_any, 1'b0);

    // write x5 then read it; write x0 then read it
    idle(); wr_en = 1; wr_addr = 5; wr_data = 32'hDEADBEEF;
    cycle("wr_x5");
    idle(); rd_en = 1; r1_addr = 5;
    cycle("rd_x5");
    chk("rd_x5_const", a_r1_data, 32'hDEADBEEF);
    idle(); wr_en = 1; wr_addr = 0; wr_data = 32'h1234;
    cycle("wr_x0");
    idle(); rd_en = 1; r1_addr = 0; r2_addr = 0;
    cycle("rd_x0");
    chk("rd_x0_const", b_r1_data, 32'h0);

    // bypass: preload x7, then write and read x7 in the same cycle
    idle(); wr_en = 1; wr_addr = 7; wr_data = 32'h11112222;
    cycle("pre_x7");
    idle(); wr_en = 1; wr_addr = 7; wr_data = 32'hA5A5A5A5; rd_en = 1; r1_addr = 7;
    cycle("byp_x7");
    chk("byp_x7_a_const", a_r1_data, 32'hA5A5A5A5);
    chk("byp_x7_b_const", b_r1_data, 32'h11112222);

    // scoreboard: reserve x9, read it busy, writeback, read it clear
    idle(); resv_en = 1; resv_addr = 9;
    cycle("resv_x9");
    idle(); rd_en = 1; r2_addr = 9;
    cycle("busy_x9");
    chk("busy_x9_const", a_r2_busy, 1'b1);
    chk("busy_x9_pend_const", b_pending_any, 1'b1);
    idle(); wr_en = 1; wr_addr = 9; wr_data = 32'h42;
    cycle("wb_x9");
    idle(); rd_en = 1; r2_addr = 9;
    cycle("clr_x9");
    chk("clr_x9_data_const", a_r2_data, 32'h42);
    chk("clr_x9_busy_const", a_r2_busy, 1'b0);

    // same-cycle reservation and writeback of x12; reservation read of x14 without write
    idle(); resv_en = 1; resv_addr = 12; wr_en = 1; wr_addr = 12; wr_data = 32'hC0FFEE12;
    rd_en = 1; r1_addr = 12;
    cycle("resv_wr_x12");
    idle(); rd_en = 1; r1_addr = 12; r2_addr = 12;
    cycle("rd_x12");
    chk("rd_x12_busy_const", a_r1_busy, 1'b1);
    chk("rd_x12_data_const", b_r2_data, 32'hC0FFEE12);
    idle(); resv_en = 1; resv_addr = 14; rd_en = 1; r1_addr = 14;
    cycle("resv_rd_x14");
    idle(); wr_en = 1; wr_addr = 12; wr_data = 32'h0;
    cycle("wb_x12");
    idle(); wr_en = 1; wr_addr = 14; wr_data = 32'h14;
    cycle("wb_x14");
    idle(); resv_en = 1; resv_addr = 0;
    cycle("resv_x0");
    chk("resv_x0_const", a_pending_any, 1'b0);

    // hold with rd_en low while x5 is rewritten
    idle(); rd_en = 1; r1_addr = 5;
    cycle("pre_hold");
    for (int i = 0; i < 3; i++) begin
      idle(); wr_en = 1; wr_addr = 5; wr_data = $urandom; r1_addr = 5;
      cycle("hold");
    end
    chk("hold_const", a_r1_data, 32'hDEADBEEF);

    // randomized traffic with one asynchronous reset in the middle
    for (int n = 0; n < 400; n++) begin
      rd_en     = ($urandom_range(0, 3) != 0);
      r1_addr   = ADDR_W'($urandom_range(0, 15));
      r2_addr   = ADDR_W'($urandom_range(0, 15));
      wr_en     = ($urandom_range(0, 1) != 0);
      wr_addr   = ADDR_W'($urandom_range(0, 15));
      wr_data   = $urandom;
      resv_en   = ($urandom_range(0, 2) == 0);
      resv_addr = ADDR_W'($urandom_range(0, 15));
      cycle("rand");
      if (n == 200) begin
        // make sure something is pending so the reset has visible effect
        idle(); resv_en = 1; resv_addr = 3; rd_en = 1; r1_addr = 5; r2_addr = 3;
        cycle("pre_async");
        chk("pre_async_pend_const", a_pending_any, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst_d_const", a_r1_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    idle(); rd_en = 1; r1_addr = 5; r2_addr = 9;
    cycle("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
